// File: rtl/sys_clock_monitor.sv
// sys_clock_monitor: frequency checker for the generated system clocks.
// It synchronises one asynchronous toggle per monitored clock into ext_clk. It then
// counts both edges of each toggle over a gate window of GATE_CYCLES ext_clk cycles.
// After each window it publishes the counts and an in-band verdict per clock, and
// keeps a sticky fault flag for any clock that left its [min, max] band.
//
// Ports:
//   ext_clk    reference clock, all logic runs here
//   rst_n      asynchronous active-low reset
//   en         level-sensitive measurement enable
//   clk_tgl    per-clock toggle inputs, asynchronous to ext_clk
//   exp_min    per-clock inclusive lower bound, slice i = [i*CNT_W +: CNT_W]
//   exp_max    per-clock inclusive upper bound, same slicing
//   fault_clr  single-cycle clear of clk_fault; a same-cycle set wins
//   freq_cnt   edge counts of the last completed window
//   cnt_valid  one-cycle pulse when freq_cnt / clk_ok update
//   clk_ok     per-clock in-band result of the last window
//   clk_fault  per-clock sticky out-of-band flag
//   busy       high while settling or counting
module sys_clock_monitor #(
  parameter int unsigned CLK_NUM     = 7,
  parameter int unsigned GATE_CYCLES = 100000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     ext_clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [CLK_NUM-1:0]       clk_tgl,
  input  logic [CLK_NUM*CNT_W-1:0] exp_min,
  input  logic [CLK_NUM*CNT_W-1:0] exp_max,
  input  logic                     fault_clr,
  output logic [CLK_NUM*CNT_W-1:0] freq_cnt,
  output logic                     cnt_valid,
  output logic [CLK_NUM-1:0]       clk_ok,
  output logic [CLK_NUM-1:0]       clk_fault,
  output logic                     busy
);

  localparam int unsigned WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Synchroniser chains and edge-detect history
  logic [CLK_NUM-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CLK_NUM-1:0]                  prev_q;
  logic [CLK_NUM-1:0]                  sync_out_c;
  logic [CLK_NUM-1:0]                  edge_c;

  // Measurement datapath
  logic [SET_W-1:0]              settle_q, settle_d;
  logic [WIN_W-1:0]              win_q, win_d;
  logic [CLK_NUM-1:0][CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CLK_NUM-1:0][CNT_W-1:0] sum_c;
  logic [CLK_NUM-1:0]            in_band_c;
  logic [CLK_NUM-1:0][CNT_W-1:0] exp_min_c, exp_max_c;

  // Output registers
  logic [CLK_NUM-1:0][CNT_W-1:0] freq_q, freq_d;
  logic [CLK_NUM-1:0]            ok_q, ok_d;
  logic [CLK_NUM-1:0]            fault_q, fault_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, busy_d;

  assign exp_min_c = exp_min;
  assign exp_max_c = exp_max;

  // Per-clock sync tap, saturating next count and band check
  for (genvar g = 0; g < CLK_NUM; g++) begin : g_ch
    assign sync_out_c[g] = sync_q[g][SYNC_STAGES-1];
    assign sum_c[g]      = (edge_c[g] && (edge_cnt_q[g] != CNT_MAX))
                         ? edge_cnt_q[g] + CNT_W'(1) : edge_cnt_q[g];
    assign in_band_c[g]  = (sum_c[g] >= exp_min_c[g]) && (sum_c[g] <= exp_max_c[g]);
  end

  // Both toggle directions are edges
  assign edge_c = sync_out_c ^ prev_q;

  // Synchronisers run in every state so history is current when counting starts
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < CLK_NUM; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], clk_tgl[i]};
      end
      prev_q <= sync_out_c;
    end
  end

  // FSM state register
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping en aborts from any active state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en)                       state_d = ST_IDLE;
        else if (settle_q == SET_LAST) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    settle_d   = settle_q;
    win_d      = win_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    ok_d       = ok_q;
    fault_d    = fault_q;
    valid_d    = 1'b0;
    busy_d     = (state_d != ST_IDLE);

    // Clear first so a set from a closing window below takes priority
    if (fault_clr) fault_d = '0;

    case (state_q)
      ST_IDLE: begin
        settle_d   = '0;
        win_d      = '0;
        edge_cnt_d = '0;
      end
      ST_SETTLE: begin
        settle_d   = settle_q + SET_W'(1);
        win_d      = '0;
        edge_cnt_d = '0;
      end
      ST_COUNT: begin
        if (!en) begin
          win_d      = '0;
          edge_cnt_d = '0;
        end else if (win_q == WIN_LAST) begin
          // Last-cycle edge belongs to the closing window; next window starts at once
          win_d      = '0;
          edge_cnt_d = '0;
          freq_d     = sum_c;
          ok_d       = in_band_c;
          fault_d    = fault_d | ~in_band_c;
          valid_d    = 1'b1;
        end else begin
          win_d      = win_q + WIN_W'(1);
          edge_cnt_d = sum_c;
        end
      end
      default: begin
        settle_d   = '0;
        win_d      = '0;
        edge_cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= '0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      ok_q       <= '0;
      fault_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      ok_q       <= ok_d;
      fault_q    <= fault_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign freq_cnt  = freq_q;
  assign clk_ok    = ok_q;
  assign clk_fault = fault_q;
  assign cnt_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sys_clock_monitor.sv
// Bench for sys_clock_monitor. There are two instances, with 12-bit and 8-bit counts.
// Both share the same stimulus and are compared every cycle against a window-level
// reference model.
module tb_sys_clock_monitor;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 12;
  localparam int unsigned W8 = 8;
  localparam int          G  = 1000;
  localparam int          S  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           en;
  logic           fault_clr;
  logic [N-1:0]   clk_tgl;
  logic [N*W-1:0] exp_min, exp_max;
  logic [N*W8-1:0] exp_min8, exp_max8;

  logic [N*W-1:0]  freq_cnt;
  logic            cnt_valid, busy;
  logic [N-1:0]    clk_ok, clk_fault;
  logic [N*W8-1:0] freq_cnt8;
  logic            cnt_valid8, busy8;
  logic [N-1:0]    clk_ok8, clk_fault8;

  sys_clock_monitor #(.CLK_NUM(N), .GATE_CYCLES(G), .CNT_W(W), .SYNC_STAGES(S)) u_dut (
    .ext_clk(clk), .rst_n(rst_n), .en(en), .clk_tgl(clk_tgl),
    .exp_min(exp_min), .exp_max(exp_max), .fault_clr(fault_clr),
    .freq_cnt(freq_cnt), .cnt_valid(cnt_valid), .clk_ok(clk_ok),
    .clk_fault(clk_fault), .busy(busy)
  );

  sys_clock_monitor #(.CLK_NUM(N), .GATE_CYCLES(G), .CNT_W(W8), .SYNC_STAGES(S)) u_sat (
    .ext_clk(clk), .rst_n(rst_n), .en(en), .clk_tgl(clk_tgl),
    .exp_min(exp_min8), .exp_max(exp_max8), .fault_clr(fault_clr),
    .freq_cnt(freq_cnt8), .cnt_valid(cnt_valid8), .clk_ok(clk_ok8),
    .clk_fault(clk_fault8), .busy(busy8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           cyc = 0;
  bit           m_meas;
  int           m_start;
  int           acc [N];
  logic [N-1:0] arrive_at [int];
  int           hp [N];
  int           ph [N];

  logic           e_valid, e_busy;
  logic [N*W-1:0] e_freq;
  logic [N-1:0]   e_ok, e_fault;
  logic [N*W8-1:0] e_freq8;
  logic [N-1:0]   e_ok8, e_fault8;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_meas = 1'b0;
    m_start = 0;
    for (int i = 0; i < N; i++) acc[i] = 0;
    arrive_at.delete();
    e_valid = 1'b0; e_busy = 1'b0;
    e_freq = '0; e_ok = '0; e_fault = '0;
    e_freq8 = '0; e_ok8 = '0; e_fault8 = '0;
  endtask

  // A pin change made after posedge c is counted at posedge c+1+S
  task automatic set_pin(input int i, input logic v);
    logic [N-1:0] tmp;
    if (v != clk_tgl[i] && rst_n === 1'b1) begin
      tmp = arrive_at.exists(cyc + 1 + S) ? arrive_at[cyc + 1 + S] : '0;
      tmp[i] = 1'b1;
      arrive_at[cyc + 1 + S] = tmp;
    end
    clk_tgl[i] = v;
  endtask

  task automatic close_window();
    int raw, f12, f8, lo, hi;
    for (int i = 0; i < N; i++) begin
      raw = acc[i];
      f12 = (raw > 4095) ? 4095 : raw;
      f8  = (raw > 255) ? 255 : raw;
      lo = int'(exp_min[i*W +: W]);  hi = int'(exp_max[i*W +: W]);
      e_freq[i*W +: W] = W'(f12);
      e_ok[i] = (f12 >= lo) && (f12 <= hi);
      if (!e_ok[i]) e_fault[i] = 1'b1;
      lo = int'(exp_min8[i*W8 +: W8]);  hi = int'(exp_max8[i*W8 +: W8]);
      e_freq8[i*W8 +: W8] = W8'(f8);
      e_ok8[i] = (f8 >= lo) && (f8 <= hi);
      if (!e_ok8[i]) e_fault8[i] = 1'b1;
      acc[i] = 0;
    end
    e_valid = 1'b1;
  endtask

  // One clock: model the edge with pre-edge inputs, check outputs, drive toggles
  task automatic tick();
    logic [N-1:0] ev;
    @(posedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      model_reset();
    end else begin
      ev = '0;
      if (arrive_at.exists(cyc)) begin
        ev = arrive_at[cyc];
        arrive_at.delete(cyc);
      end
      e_valid = 1'b0;
      if (fault_clr) begin
        e_fault = '0;
        e_fault8 = '0;
      end
      if (!m_meas) begin
        if (en) begin
          m_meas = 1'b1;
          m_start = cyc + S + 2;
          for (int i = 0; i < N; i++) acc[i] = 0;
        end
      end else if (!en) begin
        m_meas = 1'b0;
      end else if (cyc >= m_start) begin
        for (int i = 0; i < N; i++) acc[i] += int'(ev[i]);
        if ((cyc - m_start) % G == G - 1) close_window();
      end
      e_busy = m_meas;
    end
    #1;
    check_eq("cnt_valid", 64'(cnt_valid), 64'(e_valid));
    check_eq("busy", 64'(busy), 64'(e_busy));
    check_eq("freq_cnt", 64'(freq_cnt), 64'(e_freq));
    check_eq("clk_ok", 64'(clk_ok), 64'(e_ok));
    check_eq("clk_fault", 64'(clk_fault), 64'(e_fault));
    check_eq("sat_cnt_valid", 64'(cnt_valid8), 64'(e_valid));
    check_eq("sat_freq_cnt", 64'(freq_cnt8), 64'(e_freq8));
    check_eq("sat_clk_ok", 64'(clk_ok8), 64'(e_ok8));
    check_eq("sat_clk_fault", 64'(clk_fault8), 64'(e_fault8));
    for (int i = 0; i < N; i++) begin
      if (hp[i] != 0) begin
        ph[i]++;
        if (ph[i] >= hp[i]) begin
          ph[i] = 0;
          set_pin(i, ~clk_tgl[i]);
        end
      end
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cnt_valid && n < budget);
    if (!cnt_valid) check_eq("valid_timeout", 64'(cnt_valid), 64'(1));
  endtask

  // Advance until the next posedge is the last cycle of a window
  task automatic wait_boundary();
    int n = 0;
    while (!(m_meas && ((cyc + 1 - m_start) % G == G - 1)) && n < 3 * G) begin
      tick();
      n++;
    end
    check_eq("boundary_reached", 64'(busy), 64'(1));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_freq_cnt", 64'(freq_cnt), 64'(0));
    check_eq("rst_cnt_valid", 64'(cnt_valid), 64'(0));
    check_eq("rst_clk_ok", 64'(clk_ok), 64'(0));
    check_eq("rst_clk_fault", 64'(clk_fault), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    repeat (cycles) tick();
    rst_n = 1'b1;
    // Synchronisers restart from 0, so a high pin shows up as one edge
    for (int i = 0; i < N; i++) begin
      if (clk_tgl[i]) begin
        clk_tgl[i] = 1'b0;
        set_pin(i, 1'b1);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lo, hi, nom, len;
    en = 1'b0; fault_clr = 1'b0; clk_tgl = '0;
    exp_min = {12'd95, 12'd245};
    exp_max = {12'd105, 12'd255};
    exp_min8 = {8'd0, 8'd0};
    exp_max8 = {8'd200, 8'd255};
    hp[0] = 4; hp[1] = 10; ph[0] = 0; ph[1] = 0;

    // Reset with toggles running, then idle release
    do_reset(20);
    repeat (50) tick();
    check_eq("idle_busy", 64'(busy), 64'(0));

    // Nominal count and first-result latency
    en = 1'b1;
    wait_valid(3 * G, lat);
    check_eq("first_valid_lat", 64'(lat), 64'(1004));
    check_eq("nominal_freq", 64'(freq_cnt), 64'({12'd100, 12'd250}));
    check_eq("nominal_ok", 64'(clk_ok), 64'(2'b11));
    wait_valid(2 * G, lat);
    check_eq("window_period", 64'(lat), 64'(G));

    // Out of band: ch1 static
    hp[1] = 0;
    wait_valid(2 * G, lat);
    wait_valid(2 * G, lat);
    check_eq("oob_freq1", 64'(freq_cnt[23:12]), 64'(0));
    check_eq("oob_ok1", 64'(clk_ok[1]), 64'(0));
    check_eq("oob_fault1", 64'(clk_fault[1]), 64'(1));
    hp[1] = 10;
    wait_valid(2 * G, lat);
    wait_valid(2 * G, lat);
    check_eq("restored_ok", 64'(clk_ok), 64'(2'b11));
    check_eq("restored_fault_sticky", 64'(clk_fault[1]), 64'(1));

    // Clear colliding with a failing update: set wins
    hp[1] = 0;
    wait_valid(2 * G, lat);
    wait_boundary();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_eq("clr_collide_valid", 64'(cnt_valid), 64'(1));
    check_eq("clr_collide_fault", 64'(clk_fault), 64'(2'b10));
    // Clear on a passing update clears
    hp[1] = 10;
    wait_valid(2 * G, lat);
    wait_boundary();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_eq("clr_pass_fault", 64'(clk_fault), 64'(2'b00));

    // Abort at win_cnt=500, then fresh restart
    wait_valid(2 * G, lat);
    repeat (500) tick();
    en = 1'b0;
    tick();
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_freq_hold", 64'(freq_cnt), 64'({12'd100, 12'd250}));
    repeat (1100) tick();
    en = 1'b1;
    wait_valid(3 * G, lat);
    check_eq("restart_lat", 64'(lat), 64'(1004));
    check_eq("restart_freq", 64'(freq_cnt), 64'({12'd100, 12'd250}));

    // Edge on the last window cycle belongs to the closing window
    hp[0] = 0; hp[1] = 0;
    exp_min = '0; exp_max = '1;
    wait_valid(2 * G, lat);
    lat = 0;
    while (!(m_meas && (cyc + 1 + S) >= m_start && ((cyc + 1 + S - m_start) % G == G - 1))
           && lat < 3 * G) begin
      tick();
      lat++;
    end
    set_pin(0, ~clk_tgl[0]);
    tick();
    set_pin(1, ~clk_tgl[1]);
    wait_valid(2 * G, lat);
    check_eq("edge_last_closing", 64'(freq_cnt), 64'({12'd0, 12'd1}));
    wait_valid(2 * G, lat);
    check_eq("edge_first_next", 64'(freq_cnt), 64'({12'd1, 12'd0}));

    // Saturation in the 8-bit instance
    hp[0] = 2; hp[1] = 2;
    wait_valid(2 * G, lat);
    wait_valid(2 * G, lat);
    check_eq("sat_freq", 64'(freq_cnt8), 64'(16'hFFFF));
    check_eq("sat_ok", 64'(clk_ok8), 64'(2'b01));
    check_eq("nosat_freq", 64'(freq_cnt), 64'({12'd500, 12'd500}));

    // Randomised rates, bands, clears and enable drops
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        hp[i] = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(2, 16));
        nom = (hp[i] == 0) ? 0 : G / hp[i];
        if ($urandom_range(0, 2) == 0) begin
          lo = int'($urandom_range(0, 600));
          hi = int'($urandom_range(0, 600));
        end else begin
          lo = (nom > 3) ? nom - 3 : 0;
          hi = nom + 3;
        end
        exp_min[i*W +: W] = W'(lo);
        exp_max[i*W +: W] = W'(hi);
      end
      len = int'($urandom_range(300, 2500));
      for (int k = 0; k < len; k++) begin
        fault_clr = ($urandom_range(0, 299) == 0);
        if (en && $urandom_range(0, 1999) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
        tick();
      end
      fault_clr = 1'b0;
      en = 1'b1;
    end

    // Asynchronous reset in the middle of a window
    hp[0] = 4; hp[1] = 10;
    exp_min = {12'd95, 12'd245};
    exp_max = {12'd105, 12'd255};
    wait_valid(3 * G, lat);
    repeat (400) tick();
    do_reset(5);
    en = 1'b1;
    wait_valid(3 * G, lat);
    check_eq("post_reset_lat", 64'(lat), 64'(1004));
    check_eq("post_reset_freq", 64'(freq_cnt), 64'({12'd100, 12'd250}));
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
